// File: rtl/fifo_sync.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty thresholds and overflow/underflow pulses.
// Define FIFO_SYNC_FWFT_EN for first-word fall-through reads; default is a registered 1-cycle read.
module fifo_sync #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DATA_W-1:0]        din_i,
  input  logic                     wr_en_i,
  input  logic                     rd_en_i,
  output logic [DATA_W-1:0]        dout_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     almost_full_o,
  output logic                     almost_empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              wr_acc;
  logic              rd_acc;

  // Flags come straight from the counter so they can never disagree with count_o.
  assign full_o         = (count == CW'(DEPTH));
  assign empty_o        = (count == '0);
  assign almost_full_o  = (count >= CW'(AF_LEVEL));
  assign almost_empty_o = (count <= CW'(AE_LEVEL));
  assign count_o        = count;

  assign wr_acc = wr_en_i & ~full_o;
  assign rd_acc = rd_en_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o  <= wr_en_i & full_o;
      underflow_o <= rd_en_i & empty_o;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_acc) mem[wr_ptr] <= din_i;
  end

`ifdef FIFO_SYNC_FWFT_EN
  assign dout_o  = mem[rd_ptr];
  assign valid_o = ~empty_o;
`else
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= rd_acc;
      if (rd_acc) dout_o <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Scoreboard bench for fifo_sync (standard read mode, DATA_W=8, DEPTH=16).
module tb_fifo_sync;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF     = DEPTH - 2;
  localparam int AE     = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] dout;
  logic              valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]        count;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [DATA_W-1:0] sb_q[$];
  int                mcount = 0;
  logic [DATA_W-1:0] last_dout = '0;

  fifo_sync #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk_i(clk), .rst_i(rst), .din_i(din), .wr_en_i(wr_en), .rd_en_i(rd_en),
    .dout_o(dout), .valid_o(valid), .full_o(full), .empty_o(empty),
    .almost_full_o(almost_full), .almost_empty_o(almost_empty), .count_o(count),
    .overflow_o(overflow), .underflow_o(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive requests, advance the reference model, then check every output after the edge.
  task automatic step(input bit r, input bit w, input bit rd, input logic [DATA_W-1:0] d);
    bit                m_full  = (mcount == DEPTH);
    bit                m_empty = (mcount == 0);
    bit                wacc    = w && !m_full && !r;
    bit                racc    = rd && !m_empty && !r;
    bit                e_ovf   = w && m_full && !r;
    bit                e_unf   = rd && m_empty && !r;
    logic [DATA_W-1:0] e_word  = last_dout;
    rst = r; wr_en = w; rd_en = rd; din = d;
    if (r) begin
      sb_q.delete();
      mcount = 0;
      e_word = '0;
    end else begin
      if (racc) e_word = sb_q.pop_front();
      if (wacc) sb_q.push_back(d);
      mcount = mcount + (wacc ? 1 : 0) - (racc ? 1 : 0);
    end
    @(posedge clk);
    #1;
    check("count", 32'(count), 32'(mcount));
    check("full", 32'(full), 32'(mcount == DEPTH));
    check("empty", 32'(empty), 32'(mcount == 0));
    check("almost_full", 32'(almost_full), 32'(mcount >= AF));
    check("almost_empty", 32'(almost_empty), 32'(mcount <= AE));
    check("overflow", 32'(overflow), 32'(e_ovf));
    check("underflow", 32'(underflow), 32'(e_unf));
    check("valid", 32'(valid), 32'(racc));
    check("dout", 32'(dout), 32'(e_word));
    last_dout = e_word;
  endtask

  initial begin
    // Reset held with write requested: nothing may be stored or flagged.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'h55);
    step(1'b0, 1'b0, 1'b1, 8'h00);                 // read right after reset must underflow

    // Basic write/read
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 8'h00);

    // Fill past full, then drain past empty
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    check("drain_hold_0f", 32'(dout), 32'h0F);

    // Simultaneous requests at full
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
    step(1'b0, 1'b1, 1'b1, 8'hEE);
    check("both_at_full_count", 32'(count), 32'd15);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b1, 8'h00);

    // Simultaneous requests at empty
    step(1'b0, 1'b1, 1'b1, 8'h77);
    check("both_at_empty_count", 32'(count), 32'd1);
    step(1'b0, 1'b0, 1'b1, 8'h00);

    // Count 8 with both requests for 40 cycles wraps both pointers
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b1, 8'(8'h80 + i));
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 8'h00);

    // Mid-operation reset discards contents
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
    step(1'b1, 1'b1, 1'b1, 8'h99);
    step(1'b0, 1'b1, 1'b0, 8'hAA);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("post_reset_read", 32'(dout), 32'hAA);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
